// File: rtl/mov_pipe.sv
// Pipelined move unit: MOV/MVN/MOVI/MOVT with one registered output stage,
// valid/ready handshakes and an NZCV flag register. Define MOV_COND_EN for conditional execution.
module mov_pipe #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     op,
    input  logic [n-1:0]   b,
    input  logic [n-1:0]   d_old,
    input  logic [n/2-1:0] imm,
    input  logic           set_flags,
    input  logic [1:0]     cond,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [n-1:0]   c,
    output logic           exec,
    output logic [3:0]     banderas,
    output logic [3:0]     flags_q
);
    localparam int h = n / 2;

    typedef enum logic [1:0] {OP_MOV = 2'b00, OP_MVN = 2'b01, OP_MOVI = 2'b10, OP_MOVT = 2'b11} op_t;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [n-1:0] c;
        logic         exec;
        logic [3:0]   nzcv;
    } rsp_t;

    state_t       state;
    logic         accept;
    logic         cond_ok;
    logic [n-1:0] mv;
    rsp_t         rsp;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    always_comb begin
        mv = b;
        case (op_t'(op))
            OP_MOV:  mv = b;
            OP_MVN:  mv = ~b;
            OP_MOVI: mv = {{(n-h){1'b0}}, imm};
            OP_MOVT: mv = {imm, d_old[h-1:0]};
            default: mv = b;
        endcase
    end

`ifdef MOV_COND_EN
    // Condition is judged against the committed flags, which already include
    // the previous accepted move, so back-to-back dependants need no bubble.
    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = flags_q[2];
            2'b10:   cond_ok = !flags_q[2];
            2'b11:   cond_ok = flags_q[3];
            default: cond_ok = 1'b1;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^cond;
    assign cond_ok     = 1'b1;
`endif

    always_comb begin
        rsp.exec = cond_ok;
        if (cond_ok) begin
            rsp.c    = mv;
            rsp.nzcv = {mv[n-1], (mv == '0), flags_q[1:0]};
        end else begin
            rsp.c    = d_old;
            rsp.nzcv = flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            c        <= '0;
            exec     <= 1'b0;
            banderas <= 4'b0000;
            flags_q  <= 4'b0000;
        end else if (accept) begin
            state    <= FULL;
            c        <= rsp.c;
            exec     <= rsp.exec;
            banderas <= rsp.nzcv;
            if (rsp.exec && set_flags)
                flags_q <= rsp.nzcv;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_mov_pipe.sv
// Directed bench for mov_pipe (n=32): reset, all four modes, flag update,
// back-pressure stall/drain, condition handling and reset while full.
module tb_mov_pipe;
    localparam int n = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [n-1:0]  b;
    logic [n-1:0]  d_old;
    logic [15:0]   imm;
    logic          set_flags;
    logic [1:0]    cond;
    logic          out_valid;
    logic          out_ready;
    logic [n-1:0]  c;
    logic          exec;
    logic [3:0]    banderas;
    logic [3:0]    flags_q;

    int n_cmp = 0;
    int n_bad = 0;

    mov_pipe #(.n(n)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .b(b), .d_old(d_old), .imm(imm), .set_flags(set_flags),
        .cond(cond), .out_valid(out_valid), .out_ready(out_ready), .c(c),
        .exec(exec), .banderas(banderas), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] o, input logic [n-1:0] bv, input logic [n-1:0] dv,
                       input logic [15:0] iv, input logic sf, input logic [1:0] cd);
        in_valid = 1'b1; op = o; b = bv; d_old = dv; imm = iv; set_flags = sf; cond = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; b = '0; d_old = '0; imm = '0;
        set_flags = 1'b0; cond = 2'b00; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_exec", exec, 0);
        chk("rst_banderas", banderas, 0);
        chk("rst_flags", flags_q, 0);
        chk("rst_in_ready", in_ready, 1);

        rst_n = 1'b1;
        req(2'b00, 32'h8000_0000, 32'h0, 16'h0, 1'b1, 2'b00);
        tick();
        chk("mov_valid", out_valid, 1);
        chk("mov_c", c, 32'h8000_0000);
        chk("mov_exec", exec, 1);
        chk("mov_banderas", banderas, 4'b1000);
        chk("mov_flags", flags_q, 4'b1000);

        req(2'b01, 32'hFFFF_FFFF, 32'h0, 16'h0, 1'b0, 2'b00);
        tick();
        chk("mvn_c", c, 0);
        chk("mvn_banderas", banderas, 4'b0100);
        chk("mvn_flags_kept", flags_q, 4'b1000);

        req(2'b10, 32'hFFFF_FFFF, 32'h0, 16'hBEEF, 1'b0, 2'b00);
        tick();
        chk("movi_c", c, 32'h0000_BEEF);
        chk("movi_banderas", banderas, 4'b0000);

        req(2'b11, 32'h0, 32'hAAAA_5678, 16'h1234, 1'b0, 2'b00);
        tick();
        chk("movt_c", c, 32'h1234_5678);
        chk("movt_valid", out_valid, 1);

        // Back-pressure: pending request must wait, held result stays put
        out_ready = 1'b0;
        req(2'b00, 32'h11, 32'h0, 16'h0, 1'b0, 2'b00);
        #1;
        chk("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_c", c, 32'h1234_5678);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", in_ready, 1);
        tick();
        chk("drain_c0", c, 32'h11);
        req(2'b00, 32'h22, 32'h0, 16'h0, 1'b0, 2'b00);
        tick();
        chk("drain_c1", c, 32'h22);
        chk("drain_valid1", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", out_valid, 0);
        chk("drain_c_hold", c, 32'h22);

        // Condition handling: Z=1 then NE / EQ
        req(2'b00, 32'h0, 32'h0, 16'h0, 1'b1, 2'b00);
        tick();
        chk("z_flags", flags_q, 4'b0100);
        req(2'b00, 32'h5, 32'h9, 16'h0, 1'b1, 2'b10);
        tick();
`ifdef MOV_COND_EN
        chk("ne_exec", exec, 0);
        chk("ne_c", c, 32'h9);
        chk("ne_banderas", banderas, 4'b0100);
        chk("ne_flags", flags_q, 4'b0100);
        req(2'b00, 32'h5, 32'h9, 16'h0, 1'b1, 2'b01);
        tick();
        chk("eq_exec", exec, 1);
        chk("eq_c", c, 32'h5);
        chk("eq_flags", flags_q, 4'b0000);
`else
        chk("nocond_exec", exec, 1);
        chk("nocond_c", c, 32'h5);
        chk("nocond_flags", flags_q, 4'b0000);
`endif

        // Reset while full and stalled drops the result and clears flags
        req(2'b00, 32'h8000_0000, 32'h0, 16'h0, 1'b1, 2'b00);
        tick();
        chk("pre_rst_flags", flags_q, 4'b1000);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("pre_rst_in_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_flags", flags_q, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_c", c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
